ifetch_queue: RTL
=================

# ifetch_queue

Instruction fetch front end that sits on the requester side of the memory subsystem's instruction read port. It drives `iread_addr`, takes the 3-byte `iread_data` window one cycle later, and buffers bytes in a small circular byte queue. It presents up to 3 head bytes to the decoder, which consumes 0–3 bytes per cycle. A jump flushes the queue and redirects fetch.

## Interface
- `RESETVEC`, default 16'h4000: fetch address after reset (ROM base).
- `QDEPTH`, default 8: queue capacity in bytes; legal values are 6 to 16.
- `clk`  in  1: single clock; all state is updated on posedge.
- `reset`  in  1: asynchronous, active-high reset.
- `iread_addr`  out  16: instruction read address presented to memory.
- `iread_data`  in  24: bytes at addr, addr+1, addr+2 in bits [7:0], [15:8], [23:16]; registered by memory, so it is valid the cycle after the address.
- `iread_valid`  in  1: qualifies `iread_data`.
- `jump`  in  1: redirect request.
- `jump_addr`  in  16: redirect target.
- `insn_data`  out  24: head bytes, with the head byte in [7:0]; bytes beyond `insn_avail` are don't-care.
- `insn_avail`  out  2: valid head bytes, min(count, 3).
- `insn_pc`  out  16: address of the head byte.
- `insn_consume`  in  2: bytes taken this cycle; must be ≤ `insn_avail`.

## Operation
- **State:**
  - `fetch_addr`: next byte neither queued nor in flight.
  - `req_addr`.
  - `inflight` flag.
  - byte queue with head/tail pointers modulo QDEPTH.
  - `count`: 0..QDEPTH.
  - `head_pc`.
- **Address output:** `iread_addr` = `fetch_addr`, a registered value.
- **Issue:** in cycle c, issue when `!jump && count + 3*inflight + 3 <= QDEPTH`. On issue: `req_addr <= fetch_addr`, `fetch_addr <= fetch_addr + 3`, `inflight <= 1`; otherwise `inflight <= 0`.
- **Response:** in the cycle after an issue, if `iread_valid`, append all 3 bytes at the tail. Space is guaranteed by the issue rule.
- **Lost response:** if `iread_valid` = 0 in the response cycle, drop the data and set `fetch_addr <= req_addr`. This rewind overrides any advance from an issue in that same cycle, and that issue is cancelled. No byte is lost or duplicated.
- **Consume:** the head pointer and `head_pc` advance by `insn_consume`. `count` is updated as count + 3·append − consume in one step, so an append and a consume in the same cycle are both applied.
- **Jump (highest priority):**
  - Next cycle: `count`=0, `inflight`=0, `fetch_addr`=`head_pc`=`jump_addr`.
  - Any response arriving in the cycle after the jump is discarded.
  - `insn_consume` in the jump cycle is ignored.
- **Arithmetic:** all addresses are 16-bit modulo 2^16, so 16'hFFFF+1 = 16'h0000. Queue pointers wrap modulo QDEPTH.
- **Illegal consume:** `insn_consume > insn_avail` is illegal; a simulation-only `$error` is required.

## Timing
- **Reset values:** `iread_addr`=RESETVEC, `insn_pc`=RESETVEC, `insn_avail`=0, `insn_data`=0, `count`=0, `inflight`=0.
- **Reset mid-operation:** clears the queue and any in-flight request immediately; the pending response is ignored.
- **Latency from jump asserted in cycle J:**
  - J+1: `iread_addr`=`jump_addr` and first issue.
  - J+2: response arrives.
  - J+3: `insn_avail`=3 (J+2 with bypass, see Configuration).
- **Memory model:** at most one request is in flight, given the memory's one-cycle latency.
- **Outputs:** `insn_data`, `insn_avail` and `insn_pc` are functions of registered state only, except on the bypass path.

## Configuration
- **`IFETCH_BYPASS_EN` defined:** when `count`=0 and a valid response arrives, `insn_data`/`insn_avail` show `iread_data`/3 in that same cycle.
  - The decoder may consume from those bytes in that cycle.
  - Unconsumed bytes are written to the queue.
  - This adds a combinational path from `iread_data` to the outputs.
- **Undefined:** responses become visible only the cycle after they are written; there is no combinational input-to-output path.

## Test plan
- **Reset:** deassert `reset` with a ROM model where byte k = k. Required: `iread_addr`=16'h4000, `insn_avail`=0 during reset; `insn_avail`=3, `insn_data`=24'h020100, `insn_pc`=16'h4000 at the cycle defined in Timing.
- **Steady drain:** consume 1 byte/cycle for 20 cycles. Required: `insn_data[7:0]` steps 0x00..0x13, `insn_pc` steps 16'h4000..16'h4013 with no gaps; `count` never exceeds QDEPTH.
- **Jump flush:** with 5 bytes queued and a request in flight, pulse `jump` with `jump_addr`=16'h4100. Required: `insn_avail`=0 at J+1, first byte 0x00 of 16'h4100 at J+3 (J+2 with bypass), no stale byte observed.
- **Address wrap:** jump to 16'hFFFE, then consume 1 byte/cycle. Required: `insn_pc` sequence 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001; `iread_addr` 16'hFFFE then 16'h0001.
- **Invalid response:** force `iread_valid`=0 for one response cycle. Required: `iread_addr` re-presents the same address the next cycle, and the consumed byte stream is identical to the run without the fault.
- **Backpressure:** `insn_consume`=0 for 10 cycles, then 3/cycle. Required: `count` saturates at 6 to 8 (QDEPTH=8), issue stops with `iread_addr` constant, then the drain resumes in order.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the instruction read port, redirect and decoder signals of ifetch_queue
//
// Signals:
//   iread_addr   - read address presented to memory (fetch side drives)
//   iread_data   - 3-byte window at iread_addr, one cycle after the address
//   iread_valid  - qualifies iread_data
//   jump         - redirect request
//   jump_addr    - redirect target
//   insn_data    - up to 3 head bytes, head byte in [7:0]
//   insn_avail   - number of valid head bytes (0..3)
//   insn_pc      - address of the head byte
//   insn_consume - bytes the decoder takes this cycle
// Modports: master = fetch queue, slave = memory/decoder environment.
interface ifetch_queue_if;
    logic [15:0] iread_addr;
    logic [23:0] iread_data;
    logic        iread_valid;
    logic        jump;
    logic [15:0] jump_addr;
    logic [23:0] insn_data;
    logic [1:0]  insn_avail;
    logic [15:0] insn_pc;
    logic [1:0]  insn_consume;
    modport master (
        output iread_addr, insn_data, insn_avail, insn_pc,
        input  iread_data, iread_valid, jump, jump_addr, insn_consume
    );
    modport slave (
        input  iread_addr, insn_data, insn_avail, insn_pc,
        output iread_data, iread_valid, jump, jump_addr, insn_consume
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end with a circular byte queue feeding the decoder
//
// Ports:
//   clk   - single clock, all state updates on posedge
//   reset - asynchronous active-high reset
//   bus   - ifetch_queue_if.master: memory read port (iread_*), redirect (jump, jump_addr)
//           and decoder side (insn_data, insn_avail, insn_pc, insn_consume)
// Parameters:
//   RESETVEC - fetch address after reset
//   QDEPTH   - queue capacity in bytes, 6..16
// Build option:
//   IFETCH_BYPASS_EN - when defined, a response arriving into an empty queue is shown
//   to the decoder in the same cycle; otherwise outputs come from registered state only.
module ifetch_queue #(
    parameter logic [15:0] RESETVEC = 16'h4000,
    parameter int          QDEPTH   = 8
) (
    input logic            clk,
    input logic            reset,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [15:0]   fetch_addr_q, fetch_addr_d;
    logic [15:0]   req_addr_q, req_addr_d;
    logic [15:0]   head_pc_q, head_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [QDEPTH];
    logic [7:0]    mem_d [QDEPTH];
    logic          append, lost, issue;
    logic [1:0]    cons;
    logic [5:0]    need;

    // Pointer advance modulo QDEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + {{(PW-1){1'b0}}, n};
        return (s >= (PW+1)'(QDEPTH)) ? PW'(s - (PW+1)'(QDEPTH)) : s[PW-1:0];
    endfunction

    always_comb begin
        // A response is only expected in the cycle after an issue; a jump discards it.
        append = inflight_q && bus.iread_valid && !bus.jump;
        lost = inflight_q && !bus.iread_valid;
        // Reserve room for the queued bytes, the one in flight and the new request.
        need = 6'(count_q) + (inflight_q ? 6'd6 : 6'd3);
        // A lost response rewinds fetch and cancels any issue in the same cycle.
        issue = !bus.jump && !lost && (need <= 6'(QDEPTH));
        cons = bus.jump ? 2'd0 : bus.insn_consume;
        mem_d = mem_q;
        if (append) begin
            mem_d[tail_q] = bus.iread_data[7:0];
            mem_d[wrap(tail_q, 2'd1)] = bus.iread_data[15:8];
            mem_d[wrap(tail_q, 2'd2)] = bus.iread_data[23:16];
        end
        head_d = bus.jump ? '0 : wrap(head_q, cons);
        tail_d = bus.jump ? '0 : append ? wrap(tail_q, 2'd3) : tail_q;
        count_d = bus.jump ? '0 : count_q + (append ? CW'(3) : '0) - CW'(cons);
        head_pc_d = bus.jump ? bus.jump_addr : head_pc_q + 16'(cons);
        fetch_addr_d = bus.jump ? bus.jump_addr :
                       lost     ? req_addr_q :
                       issue    ? fetch_addr_q + 16'd3 : fetch_addr_q;
        req_addr_d = issue ? fetch_addr_q : req_addr_q;
        inflight_d = issue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= RESETVEC;
            req_addr_q   <= RESETVEC;
            head_pc_q    <= RESETVEC;
            inflight_q   <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            mem_q        <= '{default: '0};
        end else begin
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            head_pc_q    <= head_pc_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.iread_addr = fetch_addr_q;
    assign bus.insn_pc    = head_pc_q;

`ifdef IFETCH_BYPASS_EN
    logic bypass;
    // Empty queue plus a valid response: the decoder sees the response directly;
    // the bytes are still written and the consume count retires them at the head.
    assign bypass = (count_q == '0) && append;
    assign bus.insn_avail = bypass ? 2'd3 : (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
    assign bus.insn_data  = bypass ? bus.iread_data :
                            {mem_q[wrap(head_q, 2'd2)], mem_q[wrap(head_q, 2'd1)], mem_q[head_q]};
`else
    assign bus.insn_avail = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
    assign bus.insn_data  = {mem_q[wrap(head_q, 2'd2)], mem_q[wrap(head_q, 2'd1)], mem_q[head_q]};
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && (bus.insn_consume > bus.insn_avail))
            $error("ifetch_queue: insn_consume %0d exceeds insn_avail %0d",
                   bus.insn_consume, bus.insn_avail);
    end
`endif
endmodule
